// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC sequencer: FSM encoding,
// word size and the address alignment helper.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [1:0]  ALIGN_BITS = 2'b00;

  function automatic logic [0:31] align_adr(input logic [0:31] adr);
    return {adr[0:29], ALIGN_BITS};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus of the PC sequencer: pipeline control, redirect and the
// address handshake towards instruction memory.
interface fetch_pc_unit_if;

  logic        run;
  logic        redirectValid;
  logic [0:31] redirectAdr;
  logic        fetchReady;
  logic        fetchValid;
  logic [0:31] fetchAdr;
  logic [0:31] seqAdr;
  logic        wrapErr;
  logic [0:31] fetchCount;

  modport master (
    input  run, redirectValid, redirectAdr, fetchReady,
    output fetchValid, fetchAdr, seqAdr, wrapErr, fetchCount
  );

  modport slave (
    output run, redirectValid, redirectAdr, fetchReady,
    input  fetchValid, fetchAdr, seqAdr, wrapErr, fetchCount
  );

endinterface

// File: rtl/fetch_pc_unit_incr.sv
// 32-bit incrementer shared across the codebase: s = a + 1, outC is the
// carry out of bit 0 (MSB).
module IncrementerUnit (
  input  logic [0:31] a,
  output logic [0:31] s,
  output logic        outC
);

  assign {outC, s} = {1'b0, a} + 33'd1;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC sequencer with redirect and accepted-fetch counter.
// Optional macro FETCH_WRAP_TRAP_EN: a wrapping accept traps into HALT.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [0:31] RESET_ADR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  fetch_pc_unit_if.master  bus
);

  state_t      r_state;
  logic [0:31] r_pc;
  logic [0:31] r_count;
  logic        w_fetch_valid;
  logic        w_accept;
  logic        w_wrap;
  logic [0:31] w_inc_a;
  logic [0:31] w_seq;
  state_t      w_run_or_idle;

  // Forcing the low bits to ones makes a +1 carry straight into the word index.
  assign w_inc_a = {r_pc[0:29], 2'(WORD_BYTES - 32'd1)};

  IncrementerUnit u_incr (
    .a    (w_inc_a),
    .s    (w_seq),
    .outC (w_wrap)
  );

  assign w_fetch_valid = (r_state == ST_RUN) && !bus.redirectValid;
  assign w_accept      = w_fetch_valid && bus.fetchReady;
  assign w_run_or_idle = bus.run ? ST_RUN : ST_IDLE;

  assign bus.fetchValid = w_fetch_valid;
  assign bus.fetchAdr   = r_pc;
  assign bus.seqAdr     = w_seq;
  assign bus.fetchCount = r_count;

`ifdef FETCH_WRAP_TRAP_EN
  logic r_wrap_err;

  assign bus.wrapErr = r_wrap_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= align_adr(RESET_ADR);
      r_count    <= 32'd0;
      r_wrap_err <= 1'b0;
    end else if (bus.redirectValid) begin
      r_pc       <= align_adr(bus.redirectAdr);
      r_wrap_err <= 1'b0;
      r_state    <= w_run_or_idle;
    end else if (w_accept) begin
      r_pc    <= w_seq;
      r_count <= r_count + 32'd1;
      if (w_wrap) begin
        r_wrap_err <= 1'b1;
        r_state    <= ST_HALT;
      end else begin
        r_state <= w_run_or_idle;
      end
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_run_or_idle;
        ST_RUN:  r_state <= ST_RUN;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  logic w_unused_wrap;

  assign w_unused_wrap = w_wrap;
  assign bus.wrapErr   = 1'b0;

  // Without the trap the carry is dropped and the PC simply wraps to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= align_adr(RESET_ADR);
      r_count <= 32'd0;
    end else if (bus.redirectValid) begin
      r_pc    <= align_adr(bus.redirectAdr);
      r_state <= w_run_or_idle;
    end else if (w_accept) begin
      r_pc    <= w_seq;
      r_count <= r_count + 32'd1;
      r_state <= w_run_or_idle;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_run_or_idle;
        ST_RUN:  r_state <= ST_RUN;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized bench for fetch_pc_unit against a transaction-level
// model of the fetch PC (byte address arithmetic, fetch counter, trap flag).
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_ADR = 32'h0000_1000;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk;
  logic rst;
  fetch_pc_unit_if u_if ();

  fetch_pc_unit #(.RESET_ADR(RST_ADR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_st;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_werr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = M_IDLE;
    m_pc   = RST_ADR & 32'hFFFF_FFFC;
    m_cnt  = 32'd0;
    m_werr = 1'b0;
  endtask

  // One clock: drive inputs at negedge, compare outputs, then advance the model.
  task automatic step(input logic a_rst, input logic a_run, input logic a_rv,
                      input logic [31:0] a_ra, input logic a_rdy);
    logic exp_valid;
    @(negedge clk);
    rst               = a_rst;
    u_if.run          = a_run;
    u_if.redirectValid = a_rv;
    u_if.redirectAdr  = a_ra;
    u_if.fetchReady   = a_rdy;
    #1;
    exp_valid = (m_st == M_RUN) && !a_rv;
    check("fetchValid", {31'd0, u_if.fetchValid}, {31'd0, exp_valid});
    check("fetchAdr",   u_if.fetchAdr,   m_pc);
    check("seqAdr",     u_if.seqAdr,     m_pc + 32'd4);
    check("fetchCount", u_if.fetchCount, m_cnt);
    check("wrapErr",    {31'd0, u_if.wrapErr}, {31'd0, m_werr});
    if (a_rst) begin
      model_reset();
    end else if (a_rv) begin
      m_pc   = a_ra & 32'hFFFF_FFFC;
      m_werr = 1'b0;
      m_st   = a_run ? M_RUN : M_IDLE;
    end else if (exp_valid && a_rdy) begin
      m_cnt = m_cnt + 32'd1;
`ifdef FETCH_WRAP_TRAP_EN
      if (m_pc == 32'hFFFF_FFFC) begin
        m_werr = 1'b1;
        m_st   = M_HALT;
      end else begin
        m_st = a_run ? M_RUN : M_IDLE;
      end
`else
      m_st = a_run ? M_RUN : M_IDLE;
`endif
      m_pc = m_pc + 32'd4;
    end else if (m_st == M_IDLE && a_run) begin
      m_st = M_RUN;
    end
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b1;
    u_if.run = 1'b1;
    u_if.redirectValid = 1'b0;
    u_if.redirectAdr = 32'd0;
    u_if.fetchReady = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_reset();

    // Reset start: IDLE one cycle, then three back-to-back accepts.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    check("tp_idle_valid", {31'd0, u_if.fetchValid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    check("tp_first_adr", u_if.fetchAdr, 32'h0000_1000);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    check("tp_third_adr", u_if.fetchAdr, 32'h0000_1008);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("tp_count3", u_if.fetchCount, 32'd3);

    // Backpressure at 0x2000.
    step(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      check("tp_hold_adr", u_if.fetchAdr, 32'h0000_2000);
      check("tp_hold_valid", {31'd0, u_if.fetchValid}, 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("tp_bp_next", u_if.fetchAdr, 32'h0000_2004);
    check("tp_bp_count", u_if.fetchCount, 32'd4);

    // Redirect over a stalled fetch.
    step(1'b0, 1'b1, 1'b1, 32'h0000_3007, 1'b1);
    check("tp_redir_valid", {31'd0, u_if.fetchValid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("tp_redir_adr", u_if.fetchAdr, 32'h0000_3004);
    check("tp_redir_count", u_if.fetchCount, 32'd4);

    // run drops while stalled at 0x4000.
    step(1'b0, 1'b1, 1'b1, 32'h0000_4000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("tp_rundrop_hold", {31'd0, u_if.fetchValid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("tp_rundrop_idle", {31'd0, u_if.fetchValid}, 32'd0);
    check("tp_rundrop_pc", u_if.fetchAdr, 32'h0000_4004);

    // Wrap at the top of the address space.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("tp_wrap_adr", u_if.fetchAdr, 32'h0000_0000);
`ifdef FETCH_WRAP_TRAP_EN
    check("tp_wrap_err", {31'd0, u_if.wrapErr}, 32'd1);
    check("tp_wrap_valid", {31'd0, u_if.fetchValid}, 32'd0);
`else
    check("tp_wrap_err", {31'd0, u_if.wrapErr}, 32'd0);
    check("tp_wrap_valid", {31'd0, u_if.fetchValid}, 32'd1);
`endif
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("tp_resume_adr", u_if.fetchAdr, 32'h0000_0100);
    check("tp_resume_err", {31'd0, u_if.wrapErr}, 32'd0);

    // Reset in the middle of an offered fetch drops it uncounted.
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("tp_rst_count", u_if.fetchCount, 32'd0);
    check("tp_rst_adr", u_if.fetchAdr, 32'h0000_1000);

    // Randomized traffic, biased so wraps occur.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else ra = $urandom();
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), ra, ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
